// File: rtl/plane_setup_seq.sv
// Plane-equation setup sequencer: strobes each enabled interpolator once, waits for
// coefficients to settle, then walks a 32-pixel-wide tile row by row.
module plane_setup_seq #(
    parameter int NUM_PLANES = 8,
    parameter int SETUP_LAT  = 2,
    parameter int TILE_ROWS  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tri_valid,
    output logic                    tri_ready,
    input  logic [NUM_PLANES-1:0]   tri_plane_mask,
    input  logic [5:0]              tile_x,
    input  logic [5:0]              tile_y,
    output logic [NUM_PLANES-1:0]   ip_setup,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic signed [11:0]      x_ps,
    output logic signed [11:0]      y_ps,
    output logic                    busy,
    output logic                    tri_done,
    output logic [2:0]              state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WAIT  = 3'd2,
        S_WALK  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state, state_nx;
    logic [NUM_PLANES-1:0]   pend, pend_nx, low_bit, pend_left;
    logic [3:0]              wcnt, wcnt_nx;
    logic [4:0]              row, row_nx;
    logic [5:0]              tx_q, tx_nx, ty_q, ty_nx;
    logic signed [11:0]      x_q, x_nx, y_q, y_nx;

    // Two's-complement trick isolates the lowest pending plane in one step.
    assign low_bit   = pend & (~pend + NUM_PLANES'(1));
    assign pend_left = pend & ~low_bit;

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        wcnt_nx  = wcnt;
        row_nx   = row;
        tx_nx    = tx_q;
        ty_nx    = ty_q;
        x_nx     = x_q;
        y_nx     = y_q;
        ip_setup = '0;
        case (state)
            S_IDLE: begin
                if (tri_valid) begin
                    pend_nx  = tri_plane_mask;
                    tx_nx    = tile_x;
                    ty_nx    = tile_y;
                    state_nx = (tri_plane_mask == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                ip_setup = low_bit;
                pend_nx  = pend_left;
                if (pend_left == '0) begin
                    wcnt_nx  = 4'(SETUP_LAT - 1);
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd0) begin
                    row_nx   = 5'd0;
                    x_nx     = {1'b0, tx_q, 5'd0};
                    y_nx     = {1'b0, ty_q, 5'd0};
                    state_nx = S_WALK;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            S_WALK: begin
                if (row_ready) begin
                    if (row == 5'(TILE_ROWS - 1)) begin
                        state_nx = S_DONE;
                    end else begin
                        row_nx = row + 5'd1;
                        y_nx   = y_q + 12'sd1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            pend  <= '0;
            wcnt  <= 4'd0;
            row   <= 5'd0;
            tx_q  <= 6'd0;
            ty_q  <= 6'd0;
            x_q   <= 12'sd0;
            y_q   <= 12'sd0;
        end else begin
            state <= state_nx;
            pend  <= pend_nx;
            wcnt  <= wcnt_nx;
            row   <= row_nx;
            tx_q  <= tx_nx;
            ty_q  <= ty_nx;
            x_q   <= x_nx;
            y_q   <= y_nx;
        end
    end

    assign tri_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign row_valid = (state == S_WALK);
    assign tri_done  = (state == S_DONE);
    assign x_ps      = x_q;
    assign y_ps      = y_q;
    assign state_dbg = state;

endmodule
